// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the single register-file write port between the
// in-order writeback stage and a long-latency multi-cycle unit.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   pipe_we/addr/data, pipe_stall  pipeline writeback request and stall
//   mc_valid/addr/data, mc_ready   multi-cycle result handshake
//   mc_issue/issue_addr            multi-cycle launch from execute
//   mc_issue_err                   pulse: launch rejected (busy/squash)
//   busy_mask                      registers awaiting a multi-cycle result
//   rf_we/addr/data                registered register-file write port
module wb_port_arbiter #(
    parameter int NREG       = 16,
    parameter int AW         = 4,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pipe_we,
    input  logic [AW-1:0]   pipe_addr,
    input  logic [DW-1:0]   pipe_data,
    output logic            pipe_stall,
    input  logic            mc_valid,
    input  logic [AW-1:0]   mc_addr,
    input  logic [DW-1:0]   mc_data,
    output logic            mc_ready,
    input  logic            mc_issue,
    input  logic [AW-1:0]   mc_issue_addr,
    output logic            mc_issue_err,
    output logic [NREG-1:0] busy_mask,
    output logic            rf_we,
    output logic [AW-1:0]   rf_addr,
    output logic [DW-1:0]   rf_data
);

    typedef enum logic {
        S_NORMAL = 1'b0,
        S_DRAIN  = 1'b1
    } state_t;

    localparam logic [3:0] LP_WAIT_LAST = 4'(STARVE_MAX - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [3:0]      r_wait_cnt;
    logic [3:0]      w_wait_nxt;
    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] r_squash;
    logic [NREG-1:0] w_busy_nxt;
    logic [NREG-1:0] w_squash_nxt;
    logic            r_rf_we;
    logic [AW-1:0]   r_rf_addr;
    logic [DW-1:0]   r_rf_data;
    logic            r_issue_err;

    logic            w_pipe_commit;
    logic            w_mc_xfer;
    logic            w_mc_squashed;
    logic            w_mc_write;
    logic            w_issue_freed;
    logic            w_issue_rej;

    // Arbitration FSM: pipeline wins in NORMAL; DRAIN forces one stall.
    always_comb begin
        mc_ready    = !pipe_we;
        pipe_stall  = 1'b0;
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait_cnt;
        unique case (r_state)
            S_NORMAL: begin
                if (mc_valid && pipe_we) begin
                    w_wait_nxt = r_wait_cnt + 4'd1;
                    if (r_wait_cnt == LP_WAIT_LAST) begin
                        w_state_nxt = S_DRAIN;
                    end
                end else begin
                    // covers both an mc transfer and an absent result
                    w_wait_nxt = 4'd0;
                end
            end
            S_DRAIN: begin
                mc_ready    = 1'b1;
                pipe_stall  = pipe_we;
                w_wait_nxt  = 4'd0;
                w_state_nxt = S_NORMAL;
            end
            default: begin
                w_wait_nxt  = 4'd0;
                w_state_nxt = S_NORMAL;
            end
        endcase
    end

    assign w_pipe_commit = pipe_we && !pipe_stall;
    assign w_mc_xfer     = mc_valid && mc_ready;
    assign w_mc_squashed = r_squash[mc_addr];
    assign w_mc_write    = w_mc_xfer && !w_mc_squashed;

    // A result retiring this cycle frees its register for a same-cycle issue.
    assign w_issue_freed = w_mc_write && (mc_addr == mc_issue_addr);
    assign w_issue_rej   = mc_issue &&
                           (r_squash[mc_issue_addr] ||
                            (r_busy[mc_issue_addr] && !w_issue_freed));

    // Scoreboard: a pipeline write to a busy register makes the pending
    // multi-cycle result stale; that result is later swallowed.
    always_comb begin
        w_busy_nxt   = r_busy;
        w_squash_nxt = r_squash;
        if (w_pipe_commit && r_busy[pipe_addr]) begin
            w_busy_nxt[pipe_addr]   = 1'b0;
            w_squash_nxt[pipe_addr] = 1'b1;
        end
        if (w_mc_xfer) begin
            if (w_mc_squashed) begin
                w_squash_nxt[mc_addr] = 1'b0;
            end else begin
                w_busy_nxt[mc_addr] = 1'b0;
            end
        end
        if (mc_issue && !w_issue_rej) begin
            w_busy_nxt[mc_issue_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_NORMAL;
            r_wait_cnt <= 4'd0;
            r_busy     <= '0;
            r_squash   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
            r_busy     <= w_busy_nxt;
            r_squash   <= w_squash_nxt;
        end
    end

    // Write port: address/data hold when nobody writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rf_we     <= 1'b0;
            r_rf_addr   <= '0;
            r_rf_data   <= '0;
            r_issue_err <= 1'b0;
        end else begin
            r_issue_err <= w_issue_rej;
            if (w_pipe_commit) begin
                r_rf_we   <= 1'b1;
                r_rf_addr <= pipe_addr;
                r_rf_data <= pipe_data;
            end else if (w_mc_write) begin
                r_rf_we   <= 1'b1;
                r_rf_addr <= mc_addr;
                r_rf_data <= mc_data;
            end else begin
                r_rf_we <= 1'b0;
            end
        end
    end

    assign busy_mask    = r_busy;
    assign rf_we        = r_rf_we;
    assign rf_addr      = r_rf_addr;
    assign rf_data      = r_rf_data;
    assign mc_issue_err = r_issue_err;

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Owns the single register-file write port and shares it between two writers:
  - the in-order pipeline writeback stage (muxaddr/muxdata path);
  - a long-latency multi-cycle unit (mul/div, slow loads) that returns results out of band.
- Pipeline has priority. A starvation counter forces one pipeline stall so the multi-cycle unit can always retire.
- Keeps a per-register busy/squash scoreboard. Decode uses it for RAW stalls; it also drops WAW-stale multi-cycle results.

Parameters:
- NREG, 16, number of architectural registers (register 15 = return address).
- AW, 4, register address width (log2 NREG).
- DW, 32, data width.
- STARVE_MAX, 4, consecutive cycles a valid multi-cycle result may be blocked before a forced grant (legal range 1..15).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- pipe_we  input  1  pipeline writeback request this cycle.
- pipe_addr  input  AW  pipeline destination register.
- pipe_data  input  DW  pipeline writeback data.
- pipe_stall  output  1  combinational; pipeline write not consumed this cycle, hold WB stage and re-present.
- mc_valid  input  1  multi-cycle result valid; held with addr/data stable until accepted.
- mc_addr  input  AW  multi-cycle destination register.
- mc_data  input  DW  multi-cycle result.
- mc_ready  output  1  combinational; a result is accepted when mc_valid && mc_ready.
- mc_issue  input  1  multi-cycle op launched this cycle (from execute).
- mc_issue_addr  input  AW  destination of the launched op.
- mc_issue_err  output  1  registered one-cycle pulse; issue rejected because the target's busy or squash bit was set.
- busy_mask  output  NREG  registered; bit i = register i awaits a multi-cycle result.
- rf_we  output  1  registered write enable to register file.
- rf_addr  output  AW  registered write address.
- rf_data  output  DW  registered write data.

Behaviour:
- Reset (async, rst_n=0) clears everything:
  - rf_we=0, rf_addr=0, rf_data=0, mc_issue_err=0;
  - busy_mask=0, squash=0, wait_cnt=0, state=NORMAL.
  - Reset mid-operation discards outstanding results; the multi-cycle unit is reset on the same rst_n.
- FSM has two states, NORMAL and DRAIN.
- NORMAL:
  - mc_ready = !pipe_we; pipe_stall = 0.
  - wait_cnt increments when mc_valid && pipe_we.
  - wait_cnt clears on an mc transfer or when mc_valid=0.
  - If mc_valid && pipe_we && wait_cnt == STARVE_MAX-1, next state is DRAIN.
- DRAIN, exactly one cycle:
  - mc_ready = 1; pipe_stall = pipe_we.
  - wait_cnt clears; next state is NORMAL unconditionally, even if mc_valid dropped.
- Write port, latency 1:
  - Winner's addr/data appear on rf_* at the next rising edge with rf_we=1.
  - With no writer, rf_we=0 and rf_addr/rf_data hold their previous values.
  - A pipeline write and an mc transfer never both commit in one cycle.
- Pipeline commit (pipe_we && !pipe_stall) to register r:
  - if busy[r]=1: clear busy[r] and set squash[r], because the newer value wins.
- mc transfer to register r:
  - if squash[r]=1: result is consumed but not written (rf_we=0); clear squash[r];
  - otherwise: write it and clear busy[r].
- mc_issue to register r:
  - if busy[r] or squash[r] is set: ignored, and mc_issue_err pulses next cycle;
  - otherwise: set busy[r].
  - If in the same cycle an mc transfer clears busy[r] (unsquashed) and an issue targets r, the issue is accepted and busy[r] ends 1 (set wins, no error).
- Simultaneous pipeline commit setting squash[r] and mc transfer to r: impossible (mc_ready=0 when pipe_we=1 in NORMAL).
- busy_mask and squash update on the same edge as rf_*.

Test Plan:
- Reset: rst_n low mid-cycle with busy_mask=16'h0008 -> rf_we=0, busy_mask=0, pipe_stall=0 immediately, without waiting for a clock edge.
- Idle mc transfer: pipe_we=0, issue r3, then mc_valid with addr 3, data 32'hDEADBEEF -> mc_ready=1 same cycle; next edge rf_we=1, rf_addr=3, rf_data=32'hDEADBEEF, busy_mask bit3 cleared.
- Starvation, STARVE_MAX=4: pipe_we=1 every cycle with mc_valid held -> mc_ready=0 for 4 cycles, 5th cycle DRAIN with pipe_stall=1 and mc_ready=1; mc result written; pipeline data of stalled cycle written on the following edge.
- WAW squash: issue r5; pipeline writes r5=32'h11 -> busy bit5=0, squash set; later mc result r5=32'h22 accepted with rf_we=0; register file holds 32'h11; squash cleared.
- Issue error: issue r7 twice without completion -> second issue gives mc_issue_err=1 for one cycle, busy bit7 stays 1, single completion clears it.
- Same-cycle complete and reissue r9 -> busy bit9 stays 1, mc_issue_err=0, rf_we=1 for the completing result.
